// File: rtl/seven_seg_scan_if.sv
// rtl/seven_seg_scan_if.sv - display request/pin bundle; SEVEN_SEG_BRIGHTNESS_EN adds brightness
interface seven_seg_scan_if #(
    parameter int DIGITS = 4
);
    logic                  enable;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp;
    logic                  blank_en;
`ifdef SEVEN_SEG_BRIGHTNESS_EN
    logic [3:0]            brightness;
`endif
    logic [7:0]            seg;
    logic [DIGITS-1:0]     digit_sel;
    logic                  frame_tick;

`ifdef SEVEN_SEG_BRIGHTNESS_EN
    modport master (output enable, value, dp, blank_en, brightness,
                    input  seg, digit_sel, frame_tick);
    modport slave  (input  enable, value, dp, blank_en, brightness,
                    output seg, digit_sel, frame_tick);
`else
    modport master (output enable, value, dp, blank_en,
                    input  seg, digit_sel, frame_tick);
    modport slave  (input  enable, value, dp, blank_en,
                    output seg, digit_sel, frame_tick);
`endif
endinterface

// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - multiplexed hex seven-segment scanner; SEVEN_SEG_BRIGHTNESS_EN enables PWM dimming
module seven_seg_scan #(
    parameter int DIGITS           = 4,
    parameter int CLK_DIV          = 50000,
    parameter int DIGIT_ACTIVE_LOW = 1
) (
    input  logic           clk,
    input  logic           reset,
    seven_seg_scan_if.slave bus
);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0]  SLOT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] SEL_OFF   = (DIGIT_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [CNT_W-1:0]    slot_cnt;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] snap_value;
    logic [DIGITS-1:0]   snap_dp;
    logic                snap_blank;
    logic [7:0]          seg_q;
    logic [DIGITS-1:0]   sel_q;
    logic                tick_q;

    logic                frame_start;
    logic                lit;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blank;
    logic                zero_run;
    logic [DIGITS-1:0]   sel_on;
    logic [7:0]          seg_d;
    logic [DIGITS-1:0]   sel_d;

`ifdef SEVEN_SEG_BRIGHTNESS_EN
    logic [3:0]          pwm_cnt;
`endif

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    always_comb begin
        frame_start = (idx == '0) && (slot_cnt == '0);
        cur_nib     = 4'h0;
        cur_dp      = 1'b0;
        cur_blank   = 1'b0;
        zero_run    = 1'b1;
        // Walk from the most significant digit so zero_run means "this and all higher nibbles are zero".
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (snap_value[4*i +: 4] == 4'h0);
            if (IDX_W'(i) == idx) begin
                cur_nib   = snap_value[4*i +: 4];
                cur_dp    = snap_dp[i];
                cur_blank = snap_blank && (i != 0) && zero_run;
            end
        end

`ifdef SEVEN_SEG_BRIGHTNESS_EN
        lit = (pwm_cnt <= bus.brightness);
`else
        lit = 1'b1;
`endif

        sel_on = DIGITS'(1) << idx;
        if ((slot_cnt == '0) || !lit) begin
            seg_d = 8'hFF;
            sel_d = SEL_OFF;
        end else begin
            seg_d = {~cur_dp, cur_blank ? 7'h7F : decode(cur_nib)};
            sel_d = (DIGIT_ACTIVE_LOW != 0) ? ~sel_on : sel_on;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt   <= '0;
            idx        <= '0;
            snap_value <= '0;
            snap_dp    <= '0;
            snap_blank <= 1'b0;
            seg_q      <= 8'hFF;
            sel_q      <= SEL_OFF;
            tick_q     <= 1'b0;
        end else if (!bus.enable) begin
            slot_cnt   <= '0;
            idx        <= '0;
            seg_q      <= 8'hFF;
            sel_q      <= SEL_OFF;
            tick_q     <= 1'b0;
        end else begin
            if (slot_cnt == SLOT_LAST) begin
                slot_cnt <= '0;
                idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end
            // Snapshot only at frame start so a frame never mixes old and new digits.
            if (frame_start) begin
                snap_value <= bus.value;
                snap_dp    <= bus.dp;
                snap_blank <= bus.blank_en;
            end
            seg_q  <= seg_d;
            sel_q  <= sel_d;
            tick_q <= frame_start;
        end
    end

`ifdef SEVEN_SEG_BRIGHTNESS_EN
    always_ff @(posedge clk) begin
        if (reset || !bus.enable) begin
            pwm_cnt <= 4'h0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'h1;
        end
    end
`endif

    assign bus.seg        = seg_q;
    assign bus.digit_sel  = sel_q;
    assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_seven_seg_scan.sv
// tb/tb_seven_seg_scan.sv - directed bench for seven_seg_scan (DIGITS=4, CLK_DIV=4, active-low digits)
module tb_seven_seg_scan;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [7:0] dec [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    seven_seg_scan_if #(.DIGITS(4)) bus ();

    seven_seg_scan #(
        .DIGITS(4),
        .CLK_DIV(4),
        .DIGIT_ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // k counts cycles from the first enabled edge; img holds expected seg per digit {d3,d2,d1,d0}.
    task automatic scan_step(input int k, input logic [31:0] img);
        int slot;
        int d;
        step();
        slot = k % 4;
        d    = (k / 4) % 4;
        check("frame_tick", {7'h0, bus.frame_tick}, (k % 16 == 0) ? 8'h01 : 8'h00);
        if (slot == 0) begin
            check("guard_sel", {4'h0, bus.digit_sel}, 8'h0F);
            check("guard_seg", bus.seg, 8'hFF);
        end else begin
            check("digit_sel", {4'h0, bus.digit_sel}, {4'h0, ~(4'b0001 << d)});
            check("digit_seg", bus.seg, img[d*8 +: 8]);
        end
    endtask

    task automatic check_dark(input string tag);
        check({tag, "_seg"}, bus.seg, 8'hFF);
        check({tag, "_sel"}, {4'h0, bus.digit_sel}, 8'h0F);
        check({tag, "_tick"}, {7'h0, bus.frame_tick}, 8'h00);
    endtask

    task automatic restart();
        bus.enable = 1'b0;
        step();
        check_dark("disabled");
        bus.enable = 1'b1;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        bus.enable   = 1'b0;
        bus.value    = 16'h0000;
        bus.dp       = 4'h0;
        bus.blank_en = 1'b0;
`ifdef SEVEN_SEG_BRIGHTNESS_EN
        bus.brightness = 4'hF;
`endif
        step();
        step();
        check_dark("reset");

        reset      = 1'b0;
        bus.enable = 1'b1;
        bus.value  = 16'h1234;
        for (int k = 0; k < 32; k++) scan_step(k, 32'hF9A4B099);

        for (int n = 0; n < 16; n++) begin
            bus.value = 16'(n);
            restart();
            step();
            step();
            check($sformatf("decode_%0h", n), bus.seg, dec[n]);
            check("decode_sel", {4'h0, bus.digit_sel}, 8'h0E);
        end

        bus.value    = 16'h0050;
        bus.blank_en = 1'b1;
        bus.dp       = 4'b0100;
        restart();
        for (int k = 0; k < 16; k++) scan_step(k, 32'hFF7F92C0);

        bus.value    = 16'h1234;
        bus.blank_en = 1'b0;
        bus.dp       = 4'h0;
        restart();
        for (int k = 0; k < 6; k++) scan_step(k, 32'hF9A4B099);
        bus.value = 16'hABCD;
        for (int k = 6; k < 16; k++) scan_step(k, 32'hF9A4B099);
        for (int k = 16; k < 32; k++) scan_step(k, 32'h8883C6A1);

        bus.value = 16'h1234;
        restart();
        for (int k = 0; k < 10; k++) scan_step(k, 32'hF9A4B099);
        bus.enable = 1'b0;
        step();
        check_dark("drop_enable");
        bus.enable = 1'b1;
        for (int k = 0; k < 10; k++) scan_step(k, 32'hF9A4B099);
        reset = 1'b1;
        step();
        check_dark("mid_reset");
        reset = 1'b0;
        for (int k = 0; k < 6; k++) scan_step(k, 32'hF9A4B099);

`ifdef SEVEN_SEG_BRIGHTNESS_EN
        begin
            int lit_cnt;
            lit_cnt = 0;
            bus.brightness = 4'h3;
            restart();
            for (int k = 0; k < 64; k++) begin
                step();
                if (bus.digit_sel != 4'hF) lit_cnt++;
            end
            check("bright_lit_in_range", (lit_cnt >= 8 && lit_cnt <= 16) ? 8'h01 : 8'h00, 8'h01);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
